bcd_accumulator: RTL
====================

// Module: bcd_accumulator
// PURPOSE
//  Parametrised multi-digit BCD accumulator for the calculator/display datapath.
//  Holds an N-digit decimal value. Adds, subtracts, loads or clears it using an
//  operand accepted over a valid/ready handshake. Arithmetic runs serially, one
//  digit per cycle, with decimal carry/borrow between digits. Detects non-BCD
//  operand digits. Output feeds the 7-segment display driver.
// PARAMETERS
//  DIGITS   4   number of BCD digits (>=1); data width is 4*DIGITS bits
// PORTS
//  clk        in   1          system clock, rising edge
//  rst_n      in   1          asynchronous reset, active low
//  in_valid   in   1          operand/op presented
//  in_ready   out  1          block can accept a command (IDLE only)
//  op         in   2          00 ADD, 01 SUB, 10 LOAD, 11 CLEAR
//  operand    in   4*DIGITS   BCD operand, digit 0 = bits [3:0] (least significant)
//  acc_out    out  4*DIGITS   committed accumulator value
//  out_valid  out  1          one-cycle pulse: command completed
//  carry      out  1          ADD: carry out of MSD; SUB: borrow (result wrapped below 0)
//  err        out  1          last command rejected (operand digit > 9)
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  - Reset (async, any state): state=IDLE, work reg=0, acc_out=0, in_ready=1,
//    out_valid=0, carry=0, err=0. Reset mid-CALC aborts the operation; no out_valid.
//  - Handshake: a command is accepted on a rising edge with in_valid && in_ready.
//    in_ready=1 only in IDLE. in_valid while busy is ignored; the source holds it.
//  - FSM: IDLE -> CALC (ADD/SUB with valid operand) -> DONE -> IDLE.
//         IDLE -> DONE (LOAD, CLEAR, or any rejected command) -> IDLE.
//  - Accept: operand and op are latched. Any operand digit > 9 (ADD/SUB/LOAD) sets
//    err=1, carry=0, acc unchanged, and the FSM goes to DONE.
//    Otherwise err=0 and the operand is used.
//  - LOAD: work<=operand, carry=0. CLEAR: work<=0, carry=0, err=0 (operand ignored).
//  - CALC: digit index i runs 0..DIGITS-1, one digit per cycle.
//    ADD: s = a[i] + b[i] + c, with c0 = 0.
//    SUB: s = a[i] + (9 - b[i]) + c, with c0 = 1 (ten's complement).
//    If s > 9: digit = s - 10, c = 1. Else: digit = s, c = 0.
//    Each result digit is written back into the work reg at position i.
//    After i = DIGITS-1: ADD carry = c; SUB carry = ~c (borrow). Go to DONE.
//  - DONE: acc_out <= work; out_valid = 1 for this one cycle; next state IDLE.
//    There is no backpressure on the output.
//  - Latency from the accept edge T: ADD/SUB -> out_valid in cycle T+DIGITS+1.
//    LOAD/CLEAR/error -> out_valid in cycle T+1.
//  - Wrap: the result is modulo 10^DIGITS. acc_out is stable between out_valid pulses.
//    carry and err hold until the next completion.
//  - acc_out always contains valid BCD, because only checked values are ever committed.
// STRUCTURE
//  - bcd_pkg: DIGIT_W=4, op encodings OP_ADD/OP_SUB/OP_LOAD/OP_CLEAR,
//    FSM state enum IDLE/CALC/DONE, and function is_bcd(digit).
//  - Sub-module bcd_digit_add: combinational single-digit adder.
//    Inputs a[3:0], b[3:0], sub, cin. Outputs sum[3:0], cout.
//    Instantiated once and muxed by digit index (serial datapath).
//  - Top: FSM, digit index counter (clog2(DIGITS) bits, min 1), work register,
//    output registers.
// TESTING
//  1. Reset mid-CALC (DIGITS=4): in ADD 1234+1111, assert rst_n=0 at cycle 2.
//     -> acc_out=0000, out_valid never pulses, in_ready=1 immediately.
//  2. LOAD 0x1234, then ADD 0x8766.
//     -> out_valid 5 cycles after the ADD accept, acc_out=0x0000, carry=1.
//  3. CLEAR, then SUB 0x0001.
//     -> acc_out=0x9999, carry=1 (borrow).
//     Then SUB 0x0999 -> acc_out=0x9000, carry=0.
//  4. ADD operand 0x12A4 on acc=0x0050.
//     -> out_valid 1 cycle after accept, err=1, acc_out=0x0050.
//     Next valid ADD 0x0001 -> err=0, acc_out=0x0051.
//  5. Hold in_valid through a busy period: in_ready=0 during CALC/DONE.
//     The second command is accepted exactly in the first IDLE cycle after DONE,
//     and processed exactly once.
//  6. Exhaustive digit check with DIGITS=1: all 100 pairs a,b in 0..9 for ADD and SUB.
//     -> ADD: acc=(a+b)%10, carry=(a+b>9).
//     -> SUB: acc=(a-b+10)%10, carry=(a<b).

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD accumulator datapath:
// digit width, command encodings, FSM states and a BCD digit check.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] digit);
    return (digit <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit decimal adder/subtractor.
// Subtraction adds the nine's complement of b; the caller supplies cin=1 on digit 0.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               sub,
  input  logic               cin,
  output logic [DIGIT_W-1:0] sum,
  output logic               cout
);

  logic [DIGIT_W-1:0] b_eff;
  logic [DIGIT_W:0]   s;

  always_comb begin
    b_eff = sub ? (4'd9 - b) : b;
    s     = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
    if (s > 5'd9) begin
      sum  = DIGIT_W'(s - 5'd10);
      cout = 1'b1;
    end else begin
      sum  = s[DIGIT_W-1:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_accumulator.sv
// N-digit BCD accumulator: ADD/SUB/LOAD/CLEAR over a valid/ready handshake,
// with arithmetic performed serially one digit per cycle through one digit adder.
module bcd_accumulator
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  op,
  input  logic [DIGIT_W*DIGITS-1:0]   operand,
  output logic [DIGIT_W*DIGITS-1:0]   acc_out,
  output logic                        out_valid,
  output logic                        carry,
  output logic                        err
);

  localparam int unsigned W     = DIGIT_W * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     work_q, work_d;
  logic [W-1:0]     opnd_q, opnd_d;
  op_e              op_q, op_d;
  logic             c_q, c_d;
  logic [W-1:0]     acc_d;
  logic             carry_d, err_d;

  logic               operand_ok;
  logic               sub;
  logic [DIGIT_W-1:0] dig_a, dig_b, dig_s;
  logic               dig_c;

  always_comb begin
    operand_ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!is_bcd(operand[DIGIT_W*i +: DIGIT_W])) operand_ok = 1'b0;
    end
  end

  assign sub   = (op_q == OP_SUB);
  assign dig_a = work_q[DIGIT_W*idx_q +: DIGIT_W];
  assign dig_b = opnd_q[DIGIT_W*idx_q +: DIGIT_W];

  bcd_digit_add u_digit_add (
    .a    (dig_a),
    .b    (dig_b),
    .sub  (sub),
    .cin  (c_q),
    .sum  (dig_s),
    .cout (dig_c)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  // acc_out/carry/err are loaded on the edge entering DONE, so they are
  // already valid during the out_valid cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    work_d  = work_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    c_d     = c_q;
    acc_d   = acc_out;
    carry_d = carry;
    err_d   = err;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (op_e'(op) == OP_CLEAR) begin
            work_d  = '0;
            acc_d   = '0;
            carry_d = 1'b0;
            err_d   = 1'b0;
            state_d = DONE;
          end else if (!operand_ok) begin
            carry_d = 1'b0;
            err_d   = 1'b1;
            state_d = DONE;
          end else if (op_e'(op) == OP_LOAD) begin
            work_d  = operand;
            acc_d   = operand;
            carry_d = 1'b0;
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            op_d    = op_e'(op);
            opnd_d  = operand;
            idx_d   = '0;
            c_d     = (op_e'(op) == OP_SUB);
            state_d = CALC;
          end
        end
      end

      CALC: begin
        work_d[DIGIT_W*idx_q +: DIGIT_W] = dig_s;
        c_d = dig_c;
        if (idx_q == LAST_IDX) begin
          acc_d   = work_d;
          carry_d = sub ? ~dig_c : dig_c;
          err_d   = 1'b0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      work_q  <= '0;
      opnd_q  <= '0;
      op_q    <= OP_ADD;
      c_q     <= 1'b0;
      acc_out <= '0;
      carry   <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      c_q     <= c_d;
      acc_out <= acc_d;
      carry   <= carry_d;
      err     <= err_d;
    end
  end

endmodule
